// File: rtl/temp_spi_reader_pkg.sv
// rtl/temp_spi_reader_pkg.sv - shared types and constants for the temperature sensor SPI reader
package temp_spi_reader_pkg;

  localparam int DEF_FRAME_BITS  = 16;
  localparam int DEF_HALF_PERIOD = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_e;

  // Counter width for a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_PHASE_W = cnt_width(DEF_HALF_PERIOD);
  localparam int DEF_BIT_W   = cnt_width(DEF_FRAME_BITS);

endpackage

// File: rtl/temp_spi_reader_timer.sv
// rtl/temp_spi_reader_timer.sv - half-period terminal-count timer for the SPI reader
module spi_phase_timer
  import temp_spi_reader_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic phase_done_o
);

  localparam int PW = cnt_width(HALF_PERIOD);

  logic [PW-1:0] cnt_q;

  assign phase_done_o = (cnt_q == PW'(HALF_PERIOD - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i || phase_done_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/temp_spi_reader.sv
// rtl/temp_spi_reader.sv - SPI mode-0 read frame per sample strobe, word published with a valid pulse
module temp_spi_reader
  import temp_spi_reader_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] data,
  output logic                  valid
);

  localparam int BW = cnt_width(FRAME_BITS);

  state_e                state_q;
  logic                  cs_n_q;
  logic                  sclk_q;
  logic                  valid_q;
  logic [FRAME_BITS-1:0] data_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [BW-1:0]         bit_q;
  logic                  phase_done;

  // Every segment is HALF_PERIOD long, so the timer free-runs through a frame.
  spi_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (state_q == IDLE),
    .phase_done_o (phase_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_done) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (phase_done) begin
            if (sclk_q) begin
              // miso is captured on the edge that takes sclk low.
              sclk_q  <= 1'b0;
              shift_q <= {shift_q[FRAME_BITS-2:0], miso};
            end else if (bit_q == BW'(FRAME_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= HOLD;
            end else begin
              bit_q  <= bit_q + 1'b1;
              sclk_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (phase_done) begin
            state_q <= DONE;
            cs_n_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b1;
          data_q  <= shift_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs_n  = cs_n_q;
  assign sclk  = sclk_q;
  assign busy  = (state_q != IDLE);
  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_temp_spi_reader.sv
// tb/tb_temp_spi_reader.sv - randomized self-checking bench for temp_spi_reader (two configurations)
module tb_temp_spi_reader;

  localparam int NA = 16;
  localparam int HA = 4;
  localparam int NB = 8;
  localparam int HB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a, miso_a, cs_n_a, sclk_a, busy_a, valid_a;
  logic [NA-1:0] data_a;
  logic          start_b, miso_b, cs_n_b, sclk_b, busy_b, valid_b;
  logic [NB-1:0] data_b;

  temp_spi_reader #(.FRAME_BITS(NA), .HALF_PERIOD(HA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .miso(miso_a), .cs_n(cs_n_a),
    .sclk(sclk_a), .busy(busy_a), .data(data_a), .valid(valid_a)
  );

  temp_spi_reader #(.FRAME_BITS(NB), .HALF_PERIOD(HB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .miso(miso_b), .cs_n(cs_n_b),
    .sclk(sclk_b), .busy(busy_b), .data(data_b), .valid(valid_b)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sensor model: MSB presented once cs_n falls, next bit after each sclk fall.
  logic [15:0] word_a = '0, word_b = '0;
  int          idx_a = 0, idx_b = 0;
  logic        ps_a = 1'b0, ps_b = 1'b0;

  always @(negedge clk) begin
    if (cs_n_a) idx_a = 0;
    else if (ps_a && !sclk_a) idx_a++;
    ps_a   = sclk_a;
    miso_a = (idx_a < NA) ? word_a[NA-1-idx_a] : 1'b0;
    if (cs_n_b) idx_b = 0;
    else if (ps_b && !sclk_b) idx_b++;
    ps_b   = sclk_b;
    miso_b = (idx_b < NB) ? word_b[NB-1-idx_b] : 1'b0;
  end

  logic        sel = 1'b0;
  logic        mon_cs, mon_sclk, mon_busy, mon_valid;
  logic [15:0] mon_data;

  always_comb begin
    mon_cs    = sel ? cs_n_b  : cs_n_a;
    mon_sclk  = sel ? sclk_b  : sclk_a;
    mon_busy  = sel ? busy_b  : busy_a;
    mon_valid = sel ? valid_b : valid_a;
    mon_data  = sel ? {8'h00, data_b} : data_a;
  end

  task automatic drive_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  // One frame; an extra start is pulsed at sample inject_at (-1 = none).
  task automatic run_frame(input logic sel_i, input logic [15:0] w, input int inject_at);
    int n, h, lat, busy_n, rises, valids, vk, bad_runs, run;
    logic ps, cs_at_v;
    logic [15:0] got;
    logic [31:0] exp;
    n = sel_i ? NB : NA;
    h = sel_i ? HB : HA;
    lat = h * (2 * n + 2) + 1;
    exp = {16'h0, w} & ((32'd1 << n) - 1);
    busy_n = 0; rises = 0; valids = 0; vk = -1; bad_runs = 0; run = 0;
    ps = 1'b0; cs_at_v = 1'b0; got = '0;
    sel = sel_i;
    if (sel_i) word_b = w;
    else word_a = w;
    @(negedge clk);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    check("cs_fall", {31'h0, mon_cs}, 32'h0);
    for (int k = 0; k <= lat + 4; k++) begin
      if (mon_busy) busy_n++;
      if (mon_sclk && !ps) rises++;
      if (mon_sclk) run++;
      else begin
        if (ps && run != h) bad_runs++;
        run = 0;
      end
      ps = mon_sclk;
      if (mon_valid) begin
        valids++;
        vk = k;
        got = mon_data;
        cs_at_v = mon_cs;
      end
      if (k == inject_at) drive_start(1'b1);
      else if (k == inject_at + 1) drive_start(1'b0);
      @(negedge clk);
    end
    check("valid_edge", vk, lat);
    check("valid_count", valids, 1);
    check("busy_cycles", busy_n, lat);
    check("sclk_rises", rises, n);
    check("sclk_high_len", bad_runs, 0);
    check("data", {16'h0, got}, exp);
    check("cs_at_valid", {31'h0, cs_at_v}, 32'h1);
    check("data_hold", {16'h0, mon_data}, exp);
  endtask

  task automatic back_to_back();
    int nv, idle, vk2;
    logic [15:0] d0, d1;
    nv = 0; idle = 0; vk2 = -1; d0 = '0; d1 = '0;
    sel = 1'b0;
    word_a = 16'h0001;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 285; k++) begin
      if (valid_a) begin
        nv++;
        if (nv == 1) begin
          d0 = data_a;
          word_a = 16'hFFFE;
        end else if (nv == 2) begin
          d1 = data_a;
          vk2 = k;
        end
      end
      if (!busy_a && nv < 2) idle++;
      if (k == 150) start_a = 1'b0;
      @(negedge clk);
    end
    check("b2b_count", nv, 2);
    check("b2b_data0", {16'h0, d0}, 32'h0001);
    check("b2b_data1", {16'h0, d1}, 32'hFFFE);
    check("b2b_idle", idle, 1);
    check("b2b_edge2", vk2, 2 * (HA * (2 * NA + 2) + 1) + 1);
  endtask

  task automatic reset_mid_frame();
    int nv;
    nv = 0;
    sel = 1'b0;
    word_a = 16'($urandom);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    // 7 bits are shifted in by edge 56; edge 58 is inside the 8th bit.
    for (int k = 0; k < 58; k++) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy_a}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_cs_n", {31'h0, cs_n_a}, 32'h1);
    check("rst_sclk", {31'h0, sclk_a}, 32'h0);
    check("rst_busy", {31'h0, busy_a}, 32'h0);
    check("rst_data", {16'h0, data_a}, 32'h0);
    check("rst_valid", {31'h0, valid_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (valid_a || busy_a) nv++;
      @(negedge clk);
    end
    check("rst_no_valid", nv, 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("init_cs_n", {30'h0, cs_n_a, cs_n_b}, 32'h3);
    check("init_sclk", {30'h0, sclk_a, sclk_b}, 32'h0);
    check("init_busy", {30'h0, busy_a, busy_b}, 32'h0);
    check("init_valid", {30'h0, valid_a, valid_b}, 32'h0);
    check("init_data", {8'h0, data_a, data_b}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(1'b0, 16'hA5C3, -1);
    run_frame(1'b0, 16'h5A3C, 10);
    run_frame(1'b0, 16'h1234, HA * (2 * NA + 2));
    back_to_back();
    reset_mid_frame();
    for (int i = 0; i < 3; i++)
      run_frame(1'b0, 16'($urandom), int'($urandom_range(0, HA * (2 * NA + 2))));

    run_frame(1'b1, 16'h003C, -1);
    run_frame(1'b1, 16'h00C3, HB * (2 * NB + 2));
    for (int i = 0; i < 3; i++)
      run_frame(1'b1, 16'($urandom), int'($urandom_range(0, HB * (2 * NB + 2))));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
